cordic_vectoring: RTL and testbench

- Iterative (one micro-rotation per clock) CORDIC engine in vectoring mode.
- Takes a Cartesian point (x_in, y_in) in signed Q2.14 and drives y toward zero.
- Returns the gain-compensated magnitude on x_out, the residual on y_out, and the angle atan2(y, x) in radians, Q2.14, on theta_out.
- Used as a rectangular-to-polar converter with a simple valid/ack handshake toward its consumer.

---
 rtl/cordic_pkg.sv | 45 ++++
 rtl/cordic_vec_stage.sv | 43 ++++
 rtl/cordic_vectoring.sv | 142 ++++++++++++++
 tb/tb_cordic_vectoring.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the vectoring CORDIC engine:
//   - Q2.14 word format constants and default iteration/guard sizes
//   - gain-compensation constant K = 1/1.64676 in Q2.14
//   - arctangent lookup for atan(2^-i) in Q2.14
//   - controller state encoding
package cordic_pkg;

   localparam int CORDIC_WIDTH = 16;
   localparam int CORDIC_FRAC  = 14;
   localparam int CORDIC_ITER  = 16;
   localparam int CORDIC_GUARD = 2;

   // 0.607253 in Q2.14
   localparam logic signed [15:0] K_GAIN = 16'sd9949;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_SCALE,
      S_DONE
   } state_e;

   // atan(2^-idx) in Q2.14; zero beyond the table
   function automatic logic signed [15:0] atan_rom(input int unsigned idx);
      case (idx)
         0:       atan_rom = 16'sd12868;
         1:       atan_rom = 16'sd7596;
         2:       atan_rom = 16'sd4014;
         3:       atan_rom = 16'sd2037;
         4:       atan_rom = 16'sd1023;
         5:       atan_rom = 16'sd512;
         6:       atan_rom = 16'sd256;
         7:       atan_rom = 16'sd128;
         8:       atan_rom = 16'sd64;
         9:       atan_rom = 16'sd32;
         10:      atan_rom = 16'sd16;
         11:      atan_rom = 16'sd8;
         12:      atan_rom = 16'sd4;
         13:      atan_rom = 16'sd2;
         14:      atan_rom = 16'sd1;
         default: atan_rom = 16'sd0;
      endcase
   endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation.
// Ports:
//   x_i, y_i : current vector (IW-bit signed)
//   z_i      : accumulated angle (ZW-bit signed, Q2.14)
//   i_i      : iteration index (shift amount and atan table index)
//   x_o, y_o, z_o : rotated vector and updated angle
module cordic_vec_stage
   import cordic_pkg::*;
#(
   parameter int IW = 18,
   parameter int ZW = 18,
   parameter int CW = 4
) (
   input  logic signed [IW-1:0] x_i,
   input  logic signed [IW-1:0] y_i,
   input  logic signed [ZW-1:0] z_i,
   input  logic        [CW-1:0] i_i,
   output logic signed [IW-1:0] x_o,
   output logic signed [IW-1:0] y_o,
   output logic signed [ZW-1:0] z_o
);

   logic signed [IW-1:0] x_sh;
   logic signed [IW-1:0] y_sh;
   logic signed [ZW-1:0] ang;

   always_comb begin
      x_sh = x_i >>> i_i;
      y_sh = y_i >>> i_i;
      ang  = ZW'(atan_rom(32'(i_i)));
      // y negative: rotate counter-clockwise (d = +1), angle decreases
      if (y_i[IW-1]) begin
         x_o = x_i - y_sh;
         y_o = y_i + x_sh;
         z_o = z_i - ang;
      end else begin
         x_o = x_i + y_sh;
         y_o = y_i - x_sh;
         z_o = z_i + ang;
      end
   end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: rectangular (x, y) to polar (magnitude,
// angle), one micro-rotation per clock, Q2.14 in and out.
// Ports:
//   Clk, Rst      : clock, synchronous active-high reset
//   x_in, y_in    : input point, Q2.14, accepted when operands_val in IDLE
//   operands_val  : request strobe
//   ack           : consumer acknowledge of the held result
//   x_out         : gain-compensated magnitude, Q2.14
//   y_out         : residual y after the last rotation
//   theta_out     : atan2(y, x) in radians, Q2.14
//   out_valid     : result valid, held until ack
module cordic_vectoring
   import cordic_pkg::*;
#(
   parameter int WIDTH = CORDIC_WIDTH,
   parameter int ITER  = CORDIC_ITER,
   parameter int GUARD = CORDIC_GUARD
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   input  logic                    operands_val,
   input  logic                    ack,
   output logic signed [WIDTH-1:0] x_out,
   output logic signed [WIDTH-1:0] y_out,
   output logic signed [WIDTH-1:0] theta_out,
   output logic                    out_valid
);

   localparam int IW = WIDTH + GUARD;
   localparam int PW = IW + WIDTH;
   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   state_e state_q, state_d;

   logic signed [IW-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
   logic        [CW-1:0]    i_q, i_d;
   logic signed [WIDTH-1:0] x_out_q, x_out_d;
   logic signed [WIDTH-1:0] y_out_q, y_out_d;
   logic signed [WIDTH-1:0] theta_q, theta_d;
   logic                    valid_q, valid_d;

   logic signed [IW-1:0]    x_nx, y_nx, z_nx;
   logic signed [PW-1:0]    prod;

   cordic_vec_stage #(
      .IW (IW),
      .ZW (IW),
      .CW (CW)
   ) u_stage (
      .x_i (x_q),
      .y_i (y_q),
      .z_i (z_q),
      .i_i (i_q),
      .x_o (x_nx),
      .y_o (y_nx),
      .z_o (z_nx)
   );

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      i_d     = i_q;
      x_out_d = x_out_q;
      y_out_d = y_out_q;
      theta_d = theta_q;
      valid_d = valid_q;
      prod    = PW'(x_q) * PW'(K_GAIN);

      case (state_q)
         S_IDLE: begin
            if (operands_val) begin
               x_d     = IW'(x_in);
               y_d     = IW'(y_in);
               z_d     = '0;
               i_d     = '0;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            x_d = x_nx;
            y_d = y_nx;
            z_d = z_nx;
            if (i_q == LAST) begin
               i_d     = '0;
               state_d = S_SCALE;
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         S_SCALE: begin
            x_out_d = WIDTH'(prod >>> CORDIC_FRAC);
            y_out_d = WIDTH'(y_q);
            theta_d = WIDTH'(z_q);
            valid_d = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            // a request arriving with ack is dropped, not queued
            if (ack) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         i_q     <= '0;
         x_out_q <= '0;
         y_out_q <= '0;
         theta_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         i_q     <= i_d;
         x_out_q <= x_out_d;
         y_out_q <= y_out_d;
         theta_q <= theta_d;
         valid_q <= valid_d;
      end
   end

   assign x_out     = x_out_q;
   assign y_out     = y_out_q;
   assign theta_out = theta_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
module tb_cordic_vectoring;

   logic              Clk = 1'b0;
   logic              Rst;
   logic signed [15:0] x_in, y_in;
   logic              operands_val, ack;
   logic signed [15:0] x_out, y_out, theta_out;
   logic              out_valid;

   int checks = 0;
   int errors = 0;

   cordic_vectoring #(
      .WIDTH (16),
      .ITER  (16),
      .GUARD (2)
   ) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .x_in         (x_in),
      .y_in         (y_in),
      .operands_val (operands_val),
      .ack          (ack),
      .x_out        (x_out),
      .y_out        (y_out),
      .theta_out    (theta_out),
      .out_valid    (out_valid)
   );

   always #5 Clk = ~Clk;

   // issue a request; returns #1 after the accepting edge
   task automatic start_req(input logic signed [15:0] x, input logic signed [15:0] y);
      @(negedge Clk);
      x_in = x;
      y_in = y;
      operands_val = 1'b1;
      @(posedge Clk);
      #1;
      operands_val = 1'b0;
   endtask

   // edges after the accepting edge until out_valid; 0 on timeout
   task automatic wait_valid(output int lat);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge Clk);
         #1;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic check_result(input string name, input int x, input int y, input int lat);
      real exp_th, exp_mag, tol, dth, dmag;
      exp_th  = $atan2(real'(y), real'(x)) * 16384.0;
      exp_mag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      tol     = exp_mag * 0.001 + 4.0;
      checks++;
      if (lat !== 17) begin
         errors++;
         $display("FAIL %s latency: got %0d expected 17", name, lat);
      end
      dth  = real'(theta_out) - exp_th;
      dmag = real'(x_out) - exp_mag;
      checks++;
      if (dth > 4.0 || dth < -4.0) begin
         errors++;
         $display("FAIL %s theta: got %0d expected %0d +-4", name, theta_out, $rtoi(exp_th));
      end
      checks++;
      if (dmag > tol || dmag < -tol) begin
         errors++;
         $display("FAIL %s magnitude: got %0d expected %0d +-%0d", name, x_out, $rtoi(exp_mag), $rtoi(tol));
      end
      checks++;
      if (y_out > 16 || y_out < -16) begin
         errors++;
         $display("FAIL %s residual: got %0d expected within +-16", name, y_out);
      end
   endtask

   task automatic do_ack(input string name);
      logic signed [15:0] hx, hy, ht;
      hx = x_out; hy = y_out; ht = theta_out;
      @(negedge Clk);
      ack = 1'b1;
      @(posedge Clk);
      #1;
      ack = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s ack_drop: got out_valid=%0b expected 0", name, out_valid);
      end
      checks++;
      if (x_out !== hx || y_out !== hy || theta_out !== ht) begin
         errors++;
         $display("FAIL %s hold_after_ack: got %0d/%0d/%0d expected %0d/%0d/%0d",
                  name, x_out, y_out, theta_out, hx, hy, ht);
      end
   endtask

   task automatic run_vector(input string name, input logic signed [15:0] x, input logic signed [15:0] y);
      int lat;
      start_req(x, y);
      wait_valid(lat);
      check_result(name, int'(x), int'(y), lat);
      if (lat != 0) do_ack(name);
   endtask

   task automatic expect_no_valid(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int n = 0; n < cycles; n++) begin
         @(posedge Clk);
         #1;
         if (out_valid) seen = 1;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL %s spurious_valid: got out_valid=1 expected 0", name);
      end
   endtask

   task automatic test_reset;
      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      checks++;
      if (x_out !== 16'sd0 || y_out !== 16'sd0 || theta_out !== 16'sd0) begin
         errors++;
         $display("FAIL reset outputs: got %0d/%0d/%0d expected 0/0/0", x_out, y_out, theta_out);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset valid: got %0b expected 0", out_valid);
      end
      @(negedge Clk);
      Rst = 1'b0;
   endtask

   task automatic test_directed;
      run_vector("one_zero",   16'sh4000, 16'sh0000);
      run_vector("deg45",      16'sh4000, 16'sh4000);
      run_vector("neg45",      16'sh2000, 16'shE000);
      run_vector("deg30",      16'sh376D, 16'sh2000);
   endtask

   task automatic test_handshake;
      int lat, unstable;
      logic signed [15:0] hx, hy, ht;
      start_req(16'sh3000, 16'sh1000);
      wait_valid(lat);
      check_result("hs", 16'sh3000, 16'sh1000, lat);
      hx = x_out; hy = y_out; ht = theta_out;
      unstable = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge Clk);
         x_in = 16'sh1000;
         y_in = 16'shF000;
         operands_val = (n % 3 == 1);
         @(posedge Clk);
         #1;
         if (!out_valid || x_out !== hx || y_out !== hy || theta_out !== ht) unstable = 1;
      end
      operands_val = 1'b0;
      checks++;
      if (unstable != 0) begin
         errors++;
         $display("FAIL hs_hold: got changing outputs/valid expected stable %0d/%0d/%0d", hx, hy, ht);
      end
      do_ack("hs");
      expect_no_valid("hs_ignored_req", 25);
   endtask

   task automatic test_ack_with_req;
      int lat;
      start_req(16'sh4000, 16'shE000);
      wait_valid(lat);
      check_result("ackreq", 16'sh4000, 16'shE000, lat);
      @(negedge Clk);
      ack = 1'b1;
      operands_val = 1'b1;
      x_in = 16'sh2000;
      y_in = 16'sh2000;
      @(posedge Clk);
      #1;
      ack = 1'b0;
      operands_val = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ackreq drop: got out_valid=%0b expected 0", out_valid);
      end
      expect_no_valid("ackreq_dropped", 25);
   endtask

   task automatic test_reset_mid;
      start_req(16'sh2000, 16'sh3000);
      repeat (5) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      checks++;
      if (x_out !== 16'sd0 || y_out !== 16'sd0 || theta_out !== 16'sd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid outputs: got %0d/%0d/%0d/%0b expected 0/0/0/0",
                  x_out, y_out, theta_out, out_valid);
      end
      @(negedge Clk);
      Rst = 1'b0;
      expect_no_valid("reset_mid_abort", 25);
   endtask

   task automatic test_back_to_back;
      real r, a;
      int xi, yi, lat;
      for (int k = 0; k < 10; k++) begin
         r  = 16384.0 * (1.0 + real'($urandom_range(0, 900)) / 1000.0);
         a  = real'(int'($urandom_range(0, 3000)) - 1500) / 1000.0;
         xi = $rtoi(r * $cos(a));
         yi = $rtoi(r * $sin(a));
         start_req(16'(xi), 16'(yi));
         wait_valid(lat);
         check_result($sformatf("b2b%0d", k), xi, yi, lat);
         if (lat != 0) do_ack($sformatf("b2b%0d", k));
      end
   endtask

   initial begin
      Rst = 1'b1;
      operands_val = 1'b0;
      ack = 1'b0;
      x_in = '0;
      y_in = '0;
      test_reset;
      test_directed;
      test_handshake;
      test_ack_with_req;
      test_reset_mid;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
